// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: packs WIDTH accepted bits into a word and
// presents it on a one-entry valid/ready output register.
module sipo_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             cnt_last, accept, take, final_bit;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shift = {sr_q[WIDTH-2:0], bit_in};
    end else begin : g_lsb_first
      assign sr_shift = {bit_in, sr_q[WIDTH-1:1]};
    end
  endgenerate

  assign cnt_last  = (cnt_q == CntLast);
  // Only the word-completing bit can stall: it needs the output register free.
  assign bit_ready = !(cnt_last && valid_q && !word_ready);
  assign accept    = bit_valid && bit_ready;
  assign take      = valid_q && word_ready;
  assign final_bit = accept && cnt_last && !clr;

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;

    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (accept) begin
      sr_d  = sr_shift;
      cnt_d = cnt_last ? '0 : cnt_q + CntW'(1);
    end

    // A final bit arriving with a take reloads the register without a bubble.
    if (final_bit) begin
      word_d  = sr_shift;
      valid_d = 1'b1;
    end else if (take) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share stimulus and are
// checked against a queue-based word-assembly model every cycle.
module tb_sipo_deser;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n, clr, bit_in, bit_valid, word_ready;
  logic br_m, br_l, wv_m, wv_l;
  logic [W-1:0] wo_m, wo_l;
  logic [2:0] cnt_m, cnt_l;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(br_m), .word_out(wo_m), .word_valid(wv_m), .word_ready(word_ready),
    .bit_cnt(cnt_m)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(br_l), .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready),
    .bit_cnt(cnt_l)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: bits of the partial word in arrival order, plus the output word.
  bit           part[$];
  logic         m_valid;
  logic [W-1:0] m_word_m, m_word_l;

  typedef struct {
    logic [W-1:0] bits;     // sent bits[7] first
    logic [W-1:0] exp_msb;
    logic [W-1:0] exp_lsb;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input bit msb_first);
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i++) begin
      if (msb_first) r[W-1-i] = part[i];
      else           r[i]     = part[i];
    end
    return r;
  endfunction

  task automatic reset_model();
    part.delete();
    m_valid  = 1'b0;
    m_word_m = '0;
    m_word_l = '0;
  endtask

  // One clock: check handshake before the edge, advance the model, check state after it.
  task automatic cycle();
    logic exp_ready;
    bit take, acc;
    exp_ready = !(part.size() == W - 1 && m_valid && !word_ready);
    chk("bit_ready_msb", br_m, exp_ready);
    chk("bit_ready_lsb", br_l, exp_ready);
    take = m_valid && word_ready;
    acc  = bit_valid && exp_ready;
    @(posedge clk);
    #1;
    if (clr) begin
      part.delete();
    end else if (acc) begin
      part.push_back(bit_in);
      if (part.size() == W) begin
        m_word_m = pack(1'b1);
        m_word_l = pack(1'b0);
        m_valid  = 1'b1;
        take     = 1'b0;
        part.delete();
      end
    end
    if (take) m_valid = 1'b0;
    chk("word_valid_msb", wv_m, m_valid);
    chk("word_valid_lsb", wv_l, m_valid);
    chk("bit_cnt_msb", cnt_m, part.size());
    chk("bit_cnt_lsb", cnt_l, part.size());
    chk("word_out_msb", wo_m, m_word_m);
    chk("word_out_lsb", wo_l, m_word_l);
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    cycle();
  endtask

  task automatic send_word(input logic [W-1:0] v, input int nbits);
    for (int i = W - 1; i >= W - nbits; i--) send_bit(v[i]);
  endtask

  task automatic idle();
    bit_valid = 1'b0;
    cycle();
  endtask

  initial begin
    tbl[0] = '{8'hB2, 8'hB2, 8'h4D};
    tbl[1] = '{8'h01, 8'h01, 8'h80};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF};
    tbl[3] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[4] = '{8'h6A, 8'h6A, 8'h56};

    rst_n = 1'b0; clr = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b1;
    reset_model();
    #12;
    chk("reset_word_valid", wv_m, 1'b0);
    chk("reset_word_out", wo_m, 8'h00);
    chk("reset_bit_cnt", cnt_l, 3'd0);
    chk("reset_bit_ready", br_m, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back words with the consumer always ready.
    word_ready = 1'b1;
    foreach (tbl[k]) begin
      send_word(tbl[k].bits, W);
      chk("tbl_word_msb", wo_m, tbl[k].exp_msb);
      chk("tbl_word_lsb", wo_l, tbl[k].exp_lsb);
      chk("tbl_word_valid", wv_m, 1'b1);
    end
    idle();
    chk("tbl_valid_pulse", wv_m, 1'b0);

    // Backpressure: final bit of the second word stalls until the first is taken.
    word_ready = 1'b0;
    send_word(8'hB2, W);
    send_word(8'h5A, W - 1);
    bit_valid = 1'b1; bit_in = 1'b0;
    #1;
    chk("stall_bit_ready", br_m, 1'b0);
    cycle();
    chk("stall_cnt", cnt_m, 3'd7);
    chk("stall_hold_word", wo_m, 8'hB2);
    word_ready = 1'b1;
    #1;
    chk("stall_release_ready", br_m, 1'b1);
    cycle();
    chk("stall_new_word", wo_m, 8'h5A);
    chk("stall_new_valid", wv_m, 1'b1);
    idle();
    chk("stall_drained", wv_m, 1'b0);

    // clr discards the partial word and the bit sent alongside it.
    send_word(8'hD0, 5);
    clr = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    cycle();
    clr = 1'b0;
    chk("clr_cnt", cnt_m, 3'd0);
    send_word(8'h6A, W);
    chk("clr_word_msb", wo_m, 8'h6A);
    chk("clr_word_lsb", wo_l, 8'h56);

    // Asynchronous reset between clock edges, with a pending word and a partial word.
    word_ready = 1'b0;
    send_word(8'hB2, W);
    send_word(8'hF0, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_word_valid", wv_m, 1'b0);
    chk("async_bit_cnt", cnt_m, 3'd0);
    chk("async_word_out", wo_m, 8'h00);
    chk("async_word_out_lsb", wo_l, 8'h00);
    reset_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    word_ready = 1'b1;
    send_word(8'hC3, W);
    chk("post_reset_word", wo_m, 8'hC3);
    chk("post_reset_valid", wv_m, 1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      bit_valid  = ($urandom % 4) != 0;
      bit_in     = $urandom % 2;
      word_ready = ($urandom % 3) != 0;
      clr        = ($urandom % 40) == 0;
      cycle();
    end
    clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
